// File: rtl/timer_pkg.sv
// Shared definitions for the programmable timer interrupt controller.
//   state_e     : controller state (stop, run, hold-after-expiry)
//   MODE_*      : bit positions of the mode fields within the CPU write data
//   COUNT_W_DEF : default width of the down-counter
package timer_pkg;

    localparam int unsigned COUNT_W_DEF = 32;

    // Mode fields live in DATA[7:4] of a mode write.
    localparam int unsigned MODE_EN      = 4;
    localparam int unsigned MODE_RLD_WR  = 5;
    localparam int unsigned MODE_RLD_VBL = 6;
    localparam int unsigned MODE_REPEAT  = 7;

    typedef enum logic [1:0] {
        StStop = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } state_e;

endpackage

// File: rtl/timer_irq_ctrl_if.sv
// CPU write bus of the timer.
//   data          : 16-bit write data
//   wr_timer_high : strobe, data -> reload[31:16]
//   wr_timer_low  : strobe, data -> reload[15:0]
//   wr_mode       : strobe, data[7:4] -> mode
interface timer_irq_ctrl_if;

    logic [15:0] data;
    logic        wr_timer_high;
    logic        wr_timer_low;
    logic        wr_mode;

    modport master (
        output data,
        output wr_timer_high,
        output wr_timer_low,
        output wr_mode
    );

    modport slave (
        input data,
        input wr_timer_high,
        input wr_timer_low,
        input wr_mode
    );

endinterface

// File: rtl/timer_down_counter.sv
// Loadable down-counter with zero detect.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (has priority over dec)
//   dec        : decrement by one
//   load_val   : value to load
//   count      : current value
//   zero       : count == 0
module timer_down_counter #(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               dec,
    input  logic [COUNT_W-1:0] load_val,
    output logic [COUNT_W-1:0] count,
    output logic               zero
);

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec) begin
            count_d = count_q - COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/timer_irq_ctrl.sv
// Programmable down-counting timer producing a one-cycle interrupt pulse on expiry.
//   clk, reset    : clock, synchronous active-high reset
//   pixel_ce      : count enable
//   vblank_start  : start-of-vblank pulse (optional reload source)
//   cpu           : CPU write bus (reload halves, mode)
//   timer_irq     : registered one-cycle pulse per expiry
//   timer_running : high while in the run state
//   count         : current counter value (debug)
module timer_irq_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned COUNT_W = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pixel_ce,
    input  logic               vblank_start,
    timer_irq_ctrl_if.slave    cpu,
    output logic               timer_irq,
    output logic               timer_running,
    output logic [COUNT_W-1:0] count
);

    state_e      state_q, state_d;
    logic [15:0] reload_hi_q, reload_lo_q;
    logic [7:4]  mode_q;
    logic        irq_q, irq_d;

    logic               cnt_load, cnt_dec, cnt_zero;
    logic [COUNT_W-1:0] load_val;

    // Only the highest-priority strobe survives.
    logic wr_mode_eff, wr_high_eff, wr_low_eff;
    assign wr_mode_eff = cpu.wr_mode;
    assign wr_high_eff = cpu.wr_timer_high & ~cpu.wr_mode;
    assign wr_low_eff  = cpu.wr_timer_low & ~cpu.wr_mode & ~cpu.wr_timer_high;

    logic        reload_evt;
    logic        en_eff;
    logic [15:0] low_new;

    assign reload_evt = (wr_low_eff & mode_q[MODE_RLD_WR]) |
                        (vblank_start & mode_q[MODE_RLD_VBL]);
    // A reload in the same edge as a low-half write uses the freshly written half.
    assign low_new    = wr_low_eff ? cpu.data : reload_lo_q;
    assign en_eff     = wr_mode_eff ? cpu.data[MODE_EN] : mode_q[MODE_EN];

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        irq_d    = 1'b0;
        load_val = COUNT_W'({reload_hi_q, reload_lo_q});

        if (state_q == StRun && pixel_ce) begin
            if (cnt_zero) begin
                irq_d = 1'b1;
                if (mode_q[MODE_REPEAT]) begin
                    cnt_load = 1'b1;
                end else begin
                    state_d = StHold;
                end
            end else begin
                cnt_dec = 1'b1;
            end
        end

        if (wr_mode_eff) begin
            if (!cpu.data[MODE_EN]) begin
                // Disabling freezes the counter and swallows any expiry this cycle.
                state_d  = StStop;
                cnt_load = 1'b0;
                cnt_dec  = 1'b0;
                irq_d    = 1'b0;
            end else if (state_q == StStop) begin
                state_d = StRun;
            end
        end

        // Reload beats both decrement and expiry.
        if (reload_evt) begin
            state_d  = en_eff ? StRun : StStop;
            cnt_load = 1'b1;
            cnt_dec  = 1'b0;
            irq_d    = 1'b0;
            load_val = COUNT_W'({reload_hi_q, low_new});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StStop;
            reload_hi_q <= '0;
            reload_lo_q <= '0;
            mode_q      <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            if (wr_mode_eff) mode_q      <= cpu.data[7:4];
            if (wr_high_eff) reload_hi_q <= cpu.data;
            if (wr_low_eff)  reload_lo_q <= cpu.data;
        end
    end

    timer_down_counter #(
        .COUNT_W (COUNT_W)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (load_val),
        .count    (count),
        .zero     (cnt_zero)
    );

    assign timer_irq     = irq_q;
    assign timer_running = (state_q == StRun);

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed self-checking bench for timer_irq_ctrl.
module tb_timer_irq_ctrl;

    logic        clk;
    logic        reset;
    logic        pixel_ce;
    logic        vblank_start;
    logic        timer_irq;
    logic        timer_running;
    logic [31:0] count;

    int checks = 0;
    int errors = 0;

    timer_irq_ctrl_if cpu_if ();

    timer_irq_ctrl #(
        .COUNT_W (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pixel_ce      (pixel_ce),
        .vblank_start  (vblank_start),
        .cpu           (cpu_if),
        .timer_irq     (timer_irq),
        .timer_running (timer_running),
        .count         (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // kind: 0 = mode, 1 = high, 2 = low
    task automatic wr(input int kind, input logic [15:0] d);
        cpu_if.data = d;
        cpu_if.wr_mode       = (kind == 0);
        cpu_if.wr_timer_high = (kind == 1);
        cpu_if.wr_timer_low  = (kind == 2);
        step();
        cpu_if.wr_mode       = 1'b0;
        cpu_if.wr_timer_high = 1'b0;
        cpu_if.wr_timer_low  = 1'b0;
    endtask

    logic [31:0] rep_cnt [6];
    logic        rep_irq [6];

    initial begin
        reset = 1'b1;
        pixel_ce = 1'b0;
        vblank_start = 1'b0;
        cpu_if.data = '0;
        cpu_if.wr_mode = 1'b0;
        cpu_if.wr_timer_high = 1'b0;
        cpu_if.wr_timer_low = 1'b0;
        step();
        step();
        chk("rst_count", count, 0);
        chk("rst_irq", {31'd0, timer_irq}, 0);
        chk("rst_running", {31'd0, timer_running}, 0);
        reset = 1'b0;

        // Basic one-shot expiry
        wr(0, 16'h0030);
        chk("a_run_after_mode", {31'd0, timer_running}, 1);
        wr(1, 16'h0000);
        wr(2, 16'h0003);
        chk("a_load", count, 3);
        pixel_ce = 1'b1;
        step(); chk("a_cnt2", count, 2);
        step(); chk("a_cnt1", count, 1);
        step(); chk("a_cnt0", count, 0); chk("a_noirq0", {31'd0, timer_irq}, 0);
        step(); chk("a_irq", {31'd0, timer_irq}, 1); chk("a_hold", {31'd0, timer_running}, 0);
        step(); chk("a_irq_end", {31'd0, timer_irq}, 0); chk("a_hold_cnt", count, 0);

        // Repeat mode: pulse every 3 CE cycles
        pixel_ce = 1'b0;
        wr(0, 16'h00B0);
        chk("b_hold_en1", {31'd0, timer_running}, 0);
        wr(2, 16'h0002);
        chk("b_load", count, 2);
        rep_cnt = '{32'd1, 32'd0, 32'd2, 32'd1, 32'd0, 32'd2};
        rep_irq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        pixel_ce = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("b_cnt%0d", i), count, rep_cnt[i]);
            chk($sformatf("b_irq%0d", i), {31'd0, timer_irq}, {31'd0, rep_irq[i]});
        end

        // Reload 0 in repeat mode: pulse every CE cycle
        wr(2, 16'h0000);
        chk("z_load", count, 0);
        chk("z_noirq", {31'd0, timer_irq}, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("z_irq%0d", i), {31'd0, timer_irq}, 1);
        end
        pixel_ce = 1'b0;
        step();
        chk("z_irq_off", {31'd0, timer_irq}, 0);

        // Vblank reload colliding with expiry
        wr(0, 16'h00D0);
        wr(1, 16'h0000);
        wr(2, 16'h0005);
        chk("c_no_wr_reload", count, 0);
        vblank_start = 1'b1;
        step();
        vblank_start = 1'b0;
        chk("c_vbl_load", count, 5);
        pixel_ce = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("c_at_zero", count, 0);
        vblank_start = 1'b1;
        step();
        vblank_start = 1'b0;
        chk("c_collide_cnt", count, 5);
        chk("c_collide_irq", {31'd0, timer_irq}, 0);
        step();
        chk("c_after_cnt", count, 4);
        chk("c_after_irq", {31'd0, timer_irq}, 0);

        // Enable gating
        pixel_ce = 1'b0;
        wr(0, 16'h00B0);
        wr(2, 16'h0012);
        pixel_ce = 1'b1;
        step();
        step();
        chk("d_at_10", count, 32'h10);
        wr(0, 16'h0000);
        chk("d_stop", {31'd0, timer_running}, 0);
        for (int i = 0; i < 20; i++) step();
        chk("d_frozen", count, 32'h10);
        wr(0, 16'h0010);
        chk("d_resume_cnt", count, 32'h10);
        chk("d_resume_run", {31'd0, timer_running}, 1);
        step();
        chk("d_dec", count, 32'h0F);

        // Reset mid-count
        for (int i = 0; i < 14; i++) step();
        chk("e_at_1", count, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("e_rst_cnt", count, 0);
        chk("e_rst_irq", {31'd0, timer_irq}, 0);
        chk("e_rst_run", {31'd0, timer_running}, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("e_noirq%0d", i), {31'd0, timer_irq}, 0);
        end

        // Strobe priority
        pixel_ce = 1'b0;
        wr(0, 16'h0030);
        wr(1, 16'h0000);
        wr(2, 16'h0007);
        wr(0, 16'h0090);
        cpu_if.data = 16'h0030;
        cpu_if.wr_mode = 1'b1;
        cpu_if.wr_timer_low = 1'b1;
        step();
        cpu_if.wr_mode = 1'b0;
        cpu_if.wr_timer_low = 1'b0;
        chk("f_no_reload", count, 7);
        chk("f_running", {31'd0, timer_running}, 1);
        pixel_ce = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("f_at_zero", count, 0);
        step();
        chk("f_irq", {31'd0, timer_irq}, 1);
        chk("f_repeat_cleared", {31'd0, timer_running}, 0);
        pixel_ce = 1'b0;
        wr(0, 16'h00D0);
        chk("f_hold_stays", {31'd0, timer_running}, 0);
        vblank_start = 1'b1;
        step();
        vblank_start = 1'b0;
        chk("f_low_kept", count, 7);
        chk("f_run_again", {31'd0, timer_running}, 1);
        wr(1, 16'h0001);
        vblank_start = 1'b1;
        step();
        vblank_start = 1'b0;
        chk("f_high_half", count, 32'h0001_0007);

        // Reset overrides strobes
        reset = 1'b1;
        cpu_if.data = 16'h0030;
        cpu_if.wr_mode = 1'b1;
        cpu_if.wr_timer_low = 1'b1;
        step();
        reset = 1'b0;
        cpu_if.wr_mode = 1'b0;
        cpu_if.wr_timer_low = 1'b0;
        chk("g_rst_cnt", count, 0);
        chk("g_rst_run", {31'd0, timer_running}, 0);
        wr(2, 16'h0004);
        chk("g_mode_cleared_cnt", count, 0);
        chk("g_mode_cleared_run", {31'd0, timer_running}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
